cook_timer_ctrl: RTL
====================

// Module: cook_timer_ctrl
// PURPOSE
//   Microwave control sequencer that drives the keypad encoder and consumes its output.
//   - Collects key digits into a 4-digit BCD MM:SS entry register.
//   - Gates the encoder via enablen.
//   - Counts the cook time down at 1 Hz and drives the magnetron enable.
//   - Handles door/pause/clear and raises a done flag.
//   Sits between the keypad encoder and the display/magnetron logic.
// PARAMETERS
//   TICK_DIV   1000000  clk cycles per 1 s tick (1 MHz clk); benches use 4
// PORTS
//   clk         in   1  system clock; all state changes on posedge
//   rst         in   1  synchronous reset, active-high
//   key_bcd     in   4  digit code from encoder, 0..9; values >9 ignored
//   key_valid   in   1  encoder key-held level; only the rising edge is used
//   start       in   1  start/resume request, level, sampled each cycle
//   stop_clear  in   1  stop/clear request, level, sampled each cycle
//   door_closed in   1  1 = door closed
//   enablen     out  1  encoder enable, active-low
//   min_tens    out  4  BCD minutes tens
//   min_units   out  4  BCD minutes units
//   sec_tens    out  4  BCD seconds tens
//   sec_units   out  4  BCD seconds units
//   mag_on      out  1  magnetron enable
//   done        out  1  cook finished, level
// BEHAVIOUR
//   Reset
//     - All digits = 0, state = IDLE, enablen = 0, mag_on = 0, done = 0.
//     - Tick counter = 0, key-edge register = 0.
//     - Reset in any state (including COOK) wins over every other input; mag_on = 0 after the edge.
//   Key capture
//     - kpress = key_valid & ~key_valid_q, with key_bcd <= 9.
//     - Registered: shift left one digit on the next edge:
//       min_tens <= min_units, min_units <= sec_tens, sec_tens <= sec_units, sec_units <= key_bcd.
//     - Accepted only in IDLE and ENTRY; key_valid_q updates in every state.
//   States
//     - IDLE:  kpress -> shift, go to ENTRY.
//     - ENTRY: kpress -> shift.
//              stop_clear -> clear digits, go to IDLE.
//              start & door_closed & time != 0 -> COOK, tick counter = 0.
//              start with time == 0 or door open -> ignored.
//     - COOK:  mag_on = 1, enablen = 1.
//              Tick counter counts 0..TICK_DIV-1; at terminal count it issues a 1-cycle tick and wraps to 0.
//              On tick, decrement MM:SS in BCD:
//                - sec_units 0 -> 9 with borrow; sec_tens 0 -> 5 with borrow;
//                - min_units 0 -> 9 with borrow; min_tens decrements.
//                - Entered seconds tens 6..9 count down normally.
//              If the decrement yields 00:00 -> DONE on the same edge.
//              ~door_closed or stop_clear -> PAUSE; the tick in that cycle is discarded.
//     - PAUSE: mag_on = 0, enablen = 1, tick counter held.
//              start & door_closed -> COOK; the tick counter resumes from its held value.
//              stop_clear -> clear digits, go to IDLE (stop_clear has priority over start).
//     - DONE:  mag_on = 0, done = 1, enablen = 0, digits hold 00:00.
//              stop_clear, or kpress, or door opening -> IDLE, done = 0.
//              A kpress in DONE is not shifted in.
//   Outputs
//     - Outputs are registered: state-decoded outputs change one cycle after the causing edge.
//     - Command latency from a sampled input to mag_on change = 1 clk.
//   Entry overflow
//     - A fifth and later key pushes the oldest digit out of min_tens (wrap, no error).
// STRUCTURE
//   Shared package/header mw_pkg
//     - State localparams IDLE=0, ENTRY=1, COOK=2, PAUSE=3, DONE=4 (3-bit).
//     - BCD_W=4, BCD_MAX=9, SEC_TENS_MAX=5.
//   Sub-module bcd_time_dec
//     - Combinational 4-digit MM:SS BCD decrementer with a zero flag.
//     - Instantiated once; keeps the FSM file free of borrow logic.
// TESTING (TICK_DIV=4)
//   1 rst mid-COOK: all outputs return to reset values next edge, mag_on=0.
//   2 keys 1,3,0 (separate presses) -> digits 0,1,3,0 (01:30).
//     Holding key_valid for 10 cycles shifts only once.
//   3 01:00 entered, start with door_closed=1 -> mag_on=1 after 1 clk.
//     After 4 clks reads 00:59; 00:01 -> 00:00 sets done=1, mag_on=0.
//   4 COOK at 00:10: drop door_closed in the same cycle as a tick.
//     -> PAUSE, time stays 00:10, mag_on=0.
//     close door + start -> resumes; first decrement after the remaining held count.
//   5 start with 00:00 or door open -> stays in ENTRY, mag_on=0.
//     start+stop_clear together in PAUSE -> IDLE, digits 0.
//   6 five keys 1..5 -> 23:45; key press during COOK ignored;
//     key_bcd=12 press ignored in ENTRY.

Source files
------------

// File: rtl/mw_pkg.sv
// Shared types and constants for the microwave cook-timer controller.
package mw_pkg;

  localparam int unsigned BCD_W        = 4;
  localparam logic [3:0]  BCD_MAX      = 4'd9;
  localparam logic [3:0]  SEC_TENS_MAX = 4'd5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    COOK  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  // MM:SS as four BCD digits, most significant first
  typedef struct packed {
    logic [BCD_W-1:0] min_tens;
    logic [BCD_W-1:0] min_units;
    logic [BCD_W-1:0] sec_tens;
    logic [BCD_W-1:0] sec_units;
  } mmss_t;

endpackage

// File: rtl/bcd_time_dec.sv
// Combinational MM:SS BCD decrementer with zero flags on input and result.
module bcd_time_dec
  import mw_pkg::*;
(
  input  mmss_t cur,
  output mmss_t nxt,
  output logic  cur_zero,
  output logic  nxt_zero
);

  // Ripple a one-second borrow from sec_units up to min_tens
  always_comb begin
    nxt = cur;
    if (cur.sec_units != 4'd0) begin
      nxt.sec_units = cur.sec_units - 4'd1;
    end else begin
      nxt.sec_units = BCD_MAX;
      if (cur.sec_tens != 4'd0) begin
        nxt.sec_tens = cur.sec_tens - 4'd1;
      end else begin
        nxt.sec_tens = SEC_TENS_MAX;
        if (cur.min_units != 4'd0) begin
          nxt.min_units = cur.min_units - 4'd1;
        end else begin
          nxt.min_units = BCD_MAX;
          nxt.min_tens  = cur.min_tens - 4'd1;
        end
      end
    end
    cur_zero = (cur == '0);
    nxt_zero = (nxt == '0);
  end

endmodule

// File: rtl/cook_timer_ctrl.sv
// Microwave control sequencer: key entry, 1 Hz countdown, magnetron gating.
module cook_timer_ctrl
  import mw_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_bcd,
  input  logic       key_valid,
  input  logic       start,
  input  logic       stop_clear,
  input  logic       door_closed,
  output logic       enablen,
  output logic [3:0] min_tens,
  output logic [3:0] min_units,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_units,
  output logic       mag_on,
  output logic       done
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TICK_DIV - 1);

  state_t           state, state_nx;
  mmss_t            time_q, time_nx, dec_time, shifted;
  logic             cur_zero, dec_zero;
  logic             key_valid_q;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             kpress, tick;

  bcd_time_dec u_dec (
    .cur      (time_q),
    .nxt      (dec_time),
    .cur_zero (cur_zero),
    .nxt_zero (dec_zero)
  );

  assign kpress  = key_valid & ~key_valid_q & (key_bcd <= BCD_MAX);
  assign tick    = (cnt == CNT_TERM);
  assign shifted = {time_q.min_units, time_q.sec_tens, time_q.sec_units, key_bcd};

  // Next-state, digit and tick-counter decisions
  always_comb begin
    state_nx = state;
    time_nx  = time_q;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (kpress) begin
          time_nx  = shifted;
          state_nx = ENTRY;
        end
      end
      ENTRY: begin
        if (stop_clear) begin
          time_nx  = '0;
          state_nx = IDLE;
        end else if (start && door_closed && !cur_zero) begin
          cnt_nx   = '0;
          state_nx = COOK;
        end else if (kpress) begin
          time_nx = shifted;
        end
      end
      COOK: begin
        // Pausing holds the counter, so a coincident tick is dropped and
        // the remaining count is preserved for resume.
        if (!door_closed || stop_clear) begin
          state_nx = PAUSE;
        end else if (tick) begin
          cnt_nx  = '0;
          time_nx = dec_time;
          if (dec_zero) state_nx = DONE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      PAUSE: begin
        if (stop_clear) begin
          time_nx  = '0;
          state_nx = IDLE;
        end else if (start && door_closed) begin
          state_nx = COOK;
        end
      end
      DONE: begin
        if (stop_clear || kpress || !door_closed) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, digits, counter and registered state-decoded outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      time_q      <= '0;
      cnt         <= '0;
      key_valid_q <= 1'b0;
      enablen     <= 1'b0;
      mag_on      <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nx;
      time_q      <= time_nx;
      cnt         <= cnt_nx;
      key_valid_q <= key_valid;
      enablen     <= (state_nx == COOK) || (state_nx == PAUSE);
      mag_on      <= (state_nx == COOK);
      done        <= (state_nx == DONE);
    end
  end

  assign min_tens  = time_q.min_tens;
  assign min_units = time_q.min_units;
  assign sec_tens  = time_q.sec_tens;
  assign sec_units = time_q.sec_units;

endmodule
